// File: rtl/ahb_arb_pkg.sv
// Shared AHB-Lite arbiter types: transfer encodings, address-phase bundle and round-robin helpers.
// Pure declarations, no latency or flow control of its own.
package ahb_arb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  localparam logic [2:0] HSIZE_BYTE  = 3'b000;
  localparam logic [2:0] HSIZE_HALF  = 3'b001;
  localparam logic [2:0] HSIZE_WORD  = 3'b010;
  localparam logic [2:0] HSIZE_DWORD = 3'b011;

  localparam int AHB_AW = 32;
  localparam int AHB_DW = 32;

  typedef struct packed {
    logic [AHB_AW-1:0] haddr;
    logic              hwrite;
    logic [2:0]        hsize;
    logic [3:0]        hprot;
  } addr_phase_t;

  function automatic logic [1:0] rr_next(input logic [1:0] idx, input int n);
    return (int'(idx) >= n - 1) ? 2'd0 : idx + 2'd1;
  endfunction

  // First requester after 'last', wrapping at n; returns 'last' when nobody requests.
  function automatic logic [1:0] rr_pick(input logic [3:0] req, input logic [1:0] last, input int n);
    logic [1:0] idx;
    logic [1:0] pick;
    logic       found;
    idx   = last;
    pick  = last;
    found = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (k < n) begin
        idx = rr_next(idx, n);
        if (!found && req[idx]) begin
          pick  = idx;
          found = 1'b1;
        end
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/ahb_arb_input_stage.sv
// Per-master input stage: parks an address phase that could not be forwarded and presents
// either the parked or the live phase to the arbiter with zero added latency.
module ahb_arb_input_stage
  import ahb_arb_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst,
  input  addr_phase_t i_live,
  input  logic        i_live_vld,
  input  logic        i_grant,
  output logic        o_pend,
  output logic        o_req,
  output addr_phase_t o_aph
);

  addr_phase_t r_hold;
  logic        r_pend;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_pend <= 1'b0;
      r_hold <= '0;
    end else if (i_grant) begin
      r_pend <= 1'b0;
    end else if (i_live_vld) begin
      r_pend <= 1'b1;
      r_hold <= i_live;
    end
  end

  assign o_pend = r_pend;
  assign o_req  = r_pend | i_live_vld;
  assign o_aph  = r_pend ? r_hold : i_live;

endmodule

// File: rtl/ahb_lite_master_arbiter.sv
// Round-robin sharing of one AHB-Lite slave port between NUM_MASTERS masters, zero-latency grant.
// Optional per-master stall counters on STALL_CNT when AHB_ARB_STALL_CNT_EN is defined.
module ahb_lite_master_arbiter
  import ahb_arb_pkg::*;
#(
  parameter int NUM_MASTERS = 2,
  parameter int AW          = AHB_AW,
  parameter int DW          = AHB_DW
) (
  input  logic                     HCLK,
  input  logic                     HRESET,
  input  logic [NUM_MASTERS*AW-1:0] M_HADDR,
  input  logic [NUM_MASTERS*2-1:0]  M_HTRANS,
  input  logic [NUM_MASTERS-1:0]    M_HWRITE,
  input  logic [NUM_MASTERS*3-1:0]  M_HSIZE,
  input  logic [NUM_MASTERS*4-1:0]  M_HPROT,
  input  logic [NUM_MASTERS*DW-1:0] M_HWDATA,
  output logic [DW-1:0]             M_HRDATA,
  output logic [NUM_MASTERS-1:0]    M_HREADY,
  output logic [NUM_MASTERS-1:0]    M_HRESP,
  output logic [AW-1:0]             S_HADDR,
  output logic [1:0]                S_HTRANS,
  output logic                      S_HWRITE,
  output logic [2:0]                S_HSIZE,
  output logic [3:0]                S_HPROT,
  output logic [DW-1:0]             S_HWDATA,
  input  logic [DW-1:0]             S_HRDATA,
  input  logic                      S_HREADY,
  input  logic                      S_HRESP,
  output logic [1:0]                S_HMASTER
`ifdef AHB_ARB_STALL_CNT_EN
  ,
  output logic [NUM_MASTERS*16-1:0] STALL_CNT
`endif
);

  logic [NUM_MASTERS-1:0] w_pend;
  logic [NUM_MASTERS-1:0] w_req;
  logic [NUM_MASTERS-1:0] w_live_vld;
  logic [NUM_MASTERS-1:0] w_grant;
  addr_phase_t            w_live [NUM_MASTERS];
  addr_phase_t            w_aph  [NUM_MASTERS];
  addr_phase_t            w_win_aph;
  logic [1:0]             w_winner;
  logic                   w_any;
  logic                   w_do_grant;

  logic [1:0]             r_last_grant;
  logic [1:0]             r_dph_owner;
  logic                   r_dph_valid;

`ifdef AHB_ARB_STALL_CNT_EN
  logic [15:0]            r_stall_cnt [NUM_MASTERS];
`endif

  for (genvar g = 0; g < NUM_MASTERS; g++) begin : g_in
    assign w_live[g] = '{haddr:  AHB_AW'(M_HADDR[g*AW +: AW]),
                         hwrite: M_HWRITE[g],
                         hsize:  M_HSIZE[g*3 +: 3],
                         hprot:  M_HPROT[g*4 +: 4]};
    // A live phase only counts when the master sees its own HREADY high.
    assign w_live_vld[g] = (M_HTRANS[g*2 +: 2] == HTRANS_NONSEQ) && M_HREADY[g];
    assign w_grant[g]    = w_do_grant && (w_winner == 2'(g));

    ahb_arb_input_stage u_in (
      .i_clk      (HCLK),
      .i_rst      (HRESET),
      .i_live     (w_live[g]),
      .i_live_vld (w_live_vld[g]),
      .i_grant    (w_grant[g]),
      .o_pend     (w_pend[g]),
      .o_req      (w_req[g]),
      .o_aph      (w_aph[g])
    );

`ifdef AHB_ARB_STALL_CNT_EN
    assign STALL_CNT[g*16 +: 16] = r_stall_cnt[g];
`endif
  end

  assign w_any      = |w_req;
  assign w_do_grant = S_HREADY && w_any;
  assign w_winner   = rr_pick(4'(w_req), r_last_grant, NUM_MASTERS);

  always_comb begin
    w_win_aph = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (w_winner == 2'(i)) w_win_aph = w_aph[i];
    end
  end

  always_comb begin
    S_HTRANS  = HTRANS_IDLE;
    S_HADDR   = '0;
    S_HWRITE  = 1'b0;
    S_HSIZE   = '0;
    S_HPROT   = '0;
    S_HMASTER = '0;
    if (w_do_grant) begin
      S_HTRANS  = HTRANS_NONSEQ;
      S_HADDR   = AW'(w_win_aph.haddr);
      S_HWRITE  = w_win_aph.hwrite;
      S_HSIZE   = w_win_aph.hsize;
      S_HPROT   = w_win_aph.hprot;
      S_HMASTER = w_winner;
    end
  end

  // Data-phase owner sees the slave; a parked non-owner is stalled; everyone else idles ready.
  always_comb begin
    M_HREADY = '1;
    M_HRESP  = '0;
    S_HWDATA = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (r_dph_valid && (r_dph_owner == 2'(i))) begin
        M_HREADY[i] = S_HREADY;
        M_HRESP[i]  = S_HRESP;
      end else if (w_pend[i]) begin
        M_HREADY[i] = 1'b0;
      end
      if (r_dph_owner == 2'(i)) S_HWDATA = M_HWDATA[i*DW +: DW];
    end
  end

  assign M_HRDATA = S_HRDATA;

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_last_grant <= 2'(NUM_MASTERS - 1);
      r_dph_owner  <= '0;
      r_dph_valid  <= 1'b0;
    end else if (S_HREADY) begin
      r_dph_valid <= w_any;
      if (w_any) begin
        r_last_grant <= w_winner;
        r_dph_owner  <= w_winner;
      end
    end
  end

`ifdef AHB_ARB_STALL_CNT_EN
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      for (int i = 0; i < NUM_MASTERS; i++) r_stall_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_MASTERS; i++) begin
        if (w_pend[i] && !M_HREADY[i] && (r_stall_cnt[i] != 16'hFFFF))
          r_stall_cnt[i] <= r_stall_cnt[i] + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_ahb_lite_master_arbiter.sv
// Directed bench for ahb_lite_master_arbiter with a grant scoreboard drained by a monitor.
module tb_ahb_lite_master_arbiter;

  localparam int N  = 2;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam logic [1:0] IDLE   = 2'b00;
  localparam logic [1:0] NONSEQ = 2'b10;

  logic              HCLK = 1'b0;
  logic              HRESET = 1'b1;
  logic [N*AW-1:0]   M_HADDR;
  logic [N*2-1:0]    M_HTRANS;
  logic [N-1:0]      M_HWRITE;
  logic [N*3-1:0]    M_HSIZE;
  logic [N*4-1:0]    M_HPROT;
  logic [N*DW-1:0]   M_HWDATA;
  logic [DW-1:0]     M_HRDATA;
  logic [N-1:0]      M_HREADY;
  logic [N-1:0]      M_HRESP;
  logic [AW-1:0]     S_HADDR;
  logic [1:0]        S_HTRANS;
  logic              S_HWRITE;
  logic [2:0]        S_HSIZE;
  logic [3:0]        S_HPROT;
  logic [DW-1:0]     S_HWDATA;
  logic [DW-1:0]     S_HRDATA;
  logic              S_HREADY;
  logic              S_HRESP;
  logic [1:0]        S_HMASTER;
`ifdef AHB_ARB_STALL_CNT_EN
  logic [N*16-1:0]   STALL_CNT;
`endif

  always #5 HCLK = ~HCLK;

  ahb_lite_master_arbiter #(.NUM_MASTERS(N), .AW(AW), .DW(DW)) dut (
    .HCLK      (HCLK),
    .HRESET    (HRESET),
    .M_HADDR   (M_HADDR),
    .M_HTRANS  (M_HTRANS),
    .M_HWRITE  (M_HWRITE),
    .M_HSIZE   (M_HSIZE),
    .M_HPROT   (M_HPROT),
    .M_HWDATA  (M_HWDATA),
    .M_HRDATA  (M_HRDATA),
    .M_HREADY  (M_HREADY),
    .M_HRESP   (M_HRESP),
    .S_HADDR   (S_HADDR),
    .S_HTRANS  (S_HTRANS),
    .S_HWRITE  (S_HWRITE),
    .S_HSIZE   (S_HSIZE),
    .S_HPROT   (S_HPROT),
    .S_HWDATA  (S_HWDATA),
    .S_HRDATA  (S_HRDATA),
    .S_HREADY  (S_HREADY),
    .S_HRESP   (S_HRESP),
    .S_HMASTER (S_HMASTER)
`ifdef AHB_ARB_STALL_CNT_EN
    ,
    .STALL_CNT (STALL_CNT)
`endif
  );

  typedef struct packed {
    logic [1:0]  mst;
    logic [31:0] addr;
    logic        wr;
    logic [2:0]  size;
    logic [3:0]  prot;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  function automatic logic [3:0] prot_of(input int i);
    return (i == 0) ? 4'h3 : 4'h1;
  endfunction

  task automatic drv(input int i, input logic [1:0] tr, input logic [31:0] a, input logic w);
    M_HTRANS[i*2 +: 2]  = tr;
    M_HADDR[i*AW +: AW] = a;
    M_HWRITE[i]         = w;
    M_HSIZE[i*3 +: 3]   = 3'b010;
    M_HPROT[i*4 +: 4]   = prot_of(i);
  endtask

  task automatic expect_grant(input int i, input logic [31:0] a, input logic w);
    exp_t e;
    e.mst  = 2'(i);
    e.addr = a;
    e.wr   = w;
    e.size = 3'b010;
    e.prot = prot_of(i);
    exp_q.push_back(e);
  endtask

  task automatic next_cycle();
    @(posedge HCLK);
    #1;
  endtask

  task automatic do_reset();
    HRESET = 1'b1;
    drv(0, IDLE, 32'h0, 1'b0);
    drv(1, IDLE, 32'h0, 1'b0);
    S_HREADY = 1'b1;
    S_HRESP  = 1'b0;
    next_cycle();
    next_cycle();
    HRESET = 1'b0;
  endtask

  // Every accepted slave address phase must match the next expected grant.
  always @(negedge HCLK) begin
    if (!HRESET && S_HTRANS == NONSEQ && S_HREADY) begin
      exp_t a;
      a.mst  = S_HMASTER;
      a.addr = S_HADDR;
      a.wr   = S_HWRITE;
      a.size = S_HSIZE;
      a.prot = S_HPROT;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL grant_unexpected: got 0x%0h, expected no grant", a);
      end else begin
        chk("grant", 64'(a), 64'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    logic [1:0] hr;
    int         n [2];

    M_HWDATA = '0;
    S_HRDATA = '0;
    HRESET   = 1'b1;
    drv(0, IDLE, 32'h0, 1'b0);
    drv(1, IDLE, 32'h0, 1'b0);
    S_HREADY = 1'b1;
    S_HRESP  = 1'b0;

    @(negedge HCLK);
    chk("rst_htrans",  64'(S_HTRANS),  64'(IDLE));
    chk("rst_hmaster", 64'(S_HMASTER), 64'(0));
    chk("rst_haddr",   64'(S_HADDR),   64'(0));
    chk("rst_hready",  64'(M_HREADY),  64'(2'b11));
    chk("rst_hresp",   64'(M_HRESP),   64'(2'b00));
    next_cycle();
    HRESET = 1'b0;

    // Single M0 read, zero-wait slave
    drv(0, NONSEQ, 32'h0000_0100, 1'b0);
    expect_grant(0, 32'h0000_0100, 1'b0);
    @(negedge HCLK);
    chk("t1_m1_ready_a", 64'(M_HREADY[1]), 64'(1));
    next_cycle();
    drv(0, IDLE, 32'h0, 1'b0);
    S_HRDATA = 32'h1234_5678;
    @(negedge HCLK);
    chk("t1_rdata",      64'(M_HRDATA),    64'(32'h1234_5678));
    chk("t1_m0_ready",   64'(M_HREADY[0]), 64'(1));
    chk("t1_m1_ready_b", 64'(M_HREADY[1]), 64'(1));
    chk("t1_idle",       64'(S_HTRANS),    64'(IDLE));
    next_cycle();

    // Simultaneous M0/M1 requests: M0 first, M1 replayed from the hold register
    do_reset();
    drv(0, NONSEQ, 32'h0000_0100, 1'b0);
    drv(1, NONSEQ, 32'h4000_0000, 1'b0);
    expect_grant(0, 32'h0000_0100, 1'b0);
    @(negedge HCLK);
    next_cycle();
    drv(0, IDLE, 32'h0, 1'b0);
    drv(1, IDLE, 32'hFFFF_FFF0, 1'b1);
    expect_grant(1, 32'h4000_0000, 1'b0);
    @(negedge HCLK);
    chk("t2_m1_held",  64'(M_HREADY[1]), 64'(0));
    chk("t2_m0_ready", 64'(M_HREADY[0]), 64'(1));
    next_cycle();
    drv(1, IDLE, 32'h0, 1'b0);
    S_HRDATA = 32'hA5A5_0001;
    @(negedge HCLK);
    chk("t2_m1_ready", 64'(M_HREADY[1]), 64'(1));
    chk("t2_rdata",    64'(M_HRDATA),    64'(32'hA5A5_0001));
`ifdef AHB_ARB_STALL_CNT_EN
    chk("t2_stall_m1", 64'(STALL_CNT[31:16]), 64'(1));
    chk("t2_stall_m0", 64'(STALL_CNT[15:0]),  64'(0));
`endif
    next_cycle();

    // Both masters streaming: grants alternate, each master's addresses in order
    do_reset();
    for (int k = 0; k < 9; k++)
      expect_grant(k % 2, ((k % 2) != 0 ? 32'h2000_0000 : 32'h1000_0000) + 32'(4 * (k / 2)), 1'b0);
    n[0] = 0;
    n[1] = 0;
    for (int c = 0; c < 10; c++) begin
      for (int i = 0; i < 2; i++) begin
        if (c < 8) drv(i, NONSEQ, (i != 0 ? 32'h2000_0000 : 32'h1000_0000) + 32'(4 * n[i]), 1'b0);
        else       drv(i, IDLE, 32'h0, 1'b0);
      end
      @(negedge HCLK);
      hr = M_HREADY;
      next_cycle();
      for (int i = 0; i < 2; i++) if (c < 8 && hr[i]) n[i]++;
    end
    chk("t3_all_grants_seen", 64'(exp_q.size()), 64'(0));

    // M1 write with 3 wait states while M0 requests
    do_reset();
    drv(1, NONSEQ, 32'h0000_2000, 1'b1);
    expect_grant(1, 32'h0000_2000, 1'b1);
    @(negedge HCLK);
    next_cycle();
    drv(1, IDLE, 32'h0, 1'b0);
    M_HWDATA[63:32] = 32'hDEAD_BEEF;
    drv(0, NONSEQ, 32'h0000_0300, 1'b0);
    S_HREADY = 1'b0;
    @(negedge HCLK);
    chk("t4_wdata_w1", 64'(S_HWDATA),    64'(32'hDEAD_BEEF));
    chk("t4_no_grant", 64'(S_HTRANS),    64'(IDLE));
    chk("t4_m1_wait",  64'(M_HREADY[1]), 64'(0));
    next_cycle();
    @(negedge HCLK);
    chk("t4_wdata_w2", 64'(S_HWDATA),    64'(32'hDEAD_BEEF));
    chk("t4_m0_held",  64'(M_HREADY[0]), 64'(0));
    next_cycle();
    @(negedge HCLK);
    chk("t4_wdata_w3", 64'(S_HWDATA), 64'(32'hDEAD_BEEF));
    next_cycle();
    S_HREADY = 1'b1;
    expect_grant(0, 32'h0000_0300, 1'b0);
    @(negedge HCLK);
    chk("t4_wdata_w4", 64'(S_HWDATA),    64'(32'hDEAD_BEEF));
    chk("t4_m1_done",  64'(M_HREADY[1]), 64'(1));
    next_cycle();
    drv(0, IDLE, 32'h0, 1'b0);
    M_HWDATA[31:0]  = 32'h1111_2222;
    M_HWDATA[63:32] = 32'h0;
    @(negedge HCLK);
    chk("t4_wdata_m0", 64'(S_HWDATA), 64'(32'h1111_2222));
    next_cycle();

    // Two-cycle error to M1, M0 parked meanwhile
    do_reset();
    drv(1, NONSEQ, 32'h0000_5000, 1'b0);
    expect_grant(1, 32'h0000_5000, 1'b0);
    @(negedge HCLK);
    next_cycle();
    drv(1, IDLE, 32'h0, 1'b0);
    drv(0, NONSEQ, 32'h0000_0600, 1'b0);
    S_HREADY = 1'b0;
    S_HRESP  = 1'b1;
    @(negedge HCLK);
    chk("t5_err1_resp",  64'(M_HRESP),     64'(2'b10));
    chk("t5_err1_ready", 64'(M_HREADY[1]), 64'(0));
    next_cycle();
    drv(0, IDLE, 32'h0, 1'b0);
    S_HREADY = 1'b1;
    expect_grant(0, 32'h0000_0600, 1'b0);
    @(negedge HCLK);
    chk("t5_err2_resp",  64'(M_HRESP),  64'(2'b10));
    chk("t5_err2_ready", 64'(M_HREADY), 64'(2'b10));
    next_cycle();
    S_HRESP = 1'b0;
    @(negedge HCLK);
    chk("t5_after_resp",  64'(M_HRESP),  64'(2'b00));
    chk("t5_after_ready", 64'(M_HREADY), 64'(2'b11));
    next_cycle();

    // Reset while M1 is parked: nothing replayed afterwards
    do_reset();
    drv(0, NONSEQ, 32'h0000_0700, 1'b0);
    drv(1, NONSEQ, 32'h0000_0800, 1'b0);
    expect_grant(0, 32'h0000_0700, 1'b0);
    @(negedge HCLK);
    next_cycle();
    drv(0, IDLE, 32'h0, 1'b0);
    drv(1, IDLE, 32'h0, 1'b0);
    S_HREADY = 1'b0;
    @(negedge HCLK);
    chk("t6_m1_parked", 64'(M_HREADY[1]), 64'(0));
    next_cycle();
    HRESET   = 1'b1;
    S_HREADY = 1'b1;
    @(negedge HCLK);
    chk("t6_rst_htrans", 64'(S_HTRANS), 64'(IDLE));
    chk("t6_rst_hready", 64'(M_HREADY), 64'(2'b11));
    chk("t6_rst_hresp",  64'(M_HRESP),  64'(2'b00));
`ifdef AHB_ARB_STALL_CNT_EN
    chk("t6_rst_stall",  64'(STALL_CNT), 64'(0));
`endif
    next_cycle();
    HRESET = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge HCLK);
      chk("t6_no_replay", 64'(S_HTRANS), 64'(IDLE));
      next_cycle();
    end
    chk("final_queue_empty", 64'(exp_q.size()), 64'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
